one_channel_bram_ctrl: RTL
==========================

Name: one_channel_bram_ctrl

Overview:
Sequencer for the six-line, single-channel input line buffer (six 64-bit x 512-deep BRAMs, 5-of-6 read with one-hot rotation order).
- Write side: accepts a row-major pixel-word stream and writes row r into BRAM (r mod 6).
- Read side: issues 5-row windows at vertical stride 2 with the matching one-hot order code, and flags when the line buffer's registered output is valid.
- Enforces read-after-write and write-after-read safety between the two sides.

Parameters:
DATA_WIDTH, 64, word width of stream and BRAM data
MAX_W, 512, maximum words per row (BRAM depth; address is 9 bits)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse in IDLE; latches cfg_width/cfg_height
cfg_width  in  10  words per row, 1..512
cfg_height  in  10  rows per frame, 5..1023
in_valid  in  1  stream word valid
in_ready  out  1  stream word accepted when in_valid&&in_ready
in_data  in  DATA_WIDTH  stream word
en_wr  out  6  one-hot BRAM write enable
addr_wr  out  9  write column address
data_wr  out  DATA_WIDTH  write data
rd_ready  in  1  consumer permits issue of next read column
en_rd  out  1  BRAM read enable
order  out  3  one-hot window rotation code
addr_rd_0..addr_rd_5  out  9 each  read column address; all six carry the same value
out_valid  out  1  line-buffer data_rd holds a valid 5-row column
out_last  out  1  with out_valid: final column of final window
busy  out  1  high from start until done
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: all outputs 0. State IDLE. All counters 0.
- States and transitions:
  - IDLE -> RUN on start. Latch cfg. Set K = (cfg_height-5)/2 + 1, using floor division.
  - RUN -> FLUSH when both hold: rows_written == H and windows_done == K.
  - FLUSH: waits for 2 cycles for the read pipeline, then -> IDLE.
  - done pulses on the FLUSH->IDLE transition.
  - start outside IDLE is ignored.
- Write side:
  - in_ready = RUN && rows_written < H && rows_written <= 2*windows_done + 5.
  - On accept: the next cycle registers en_wr = 1<<(rows_written mod 6), addr_wr = wr_col, data_wr = in_data. Otherwise en_wr = 0.
  - wr_col counts 0..W-1. On the accept at W-1, wr_col wraps to 0 and rows_written increments.
  - The write BRAM index wraps 5 -> 0.
- Read side:
  - Window k is eligible when rows_written >= 2k+5 and k < K.
  - While eligible and rd_ready: each cycle register en_rd = 1, addr_rd_* = rd_col, order = {k mod 3 == 2, k mod 3 == 1, k mod 3 == 0}. Otherwise en_rd = 0 and order = 0.
  - order and en_rd always change in the same cycle.
  - rd_col counts 0..W-1. On the issue at W-1, windows_done increments and k advances.
- Hazard rules:
  - Window k uses BRAMs (2k..2k+4) mod 6. Row 2k+5 may be written concurrently.
  - Row r >= 6 is blocked until windows_done >= floor((r-6)/2) + 1; this is equivalent to the in_ready rule above.
  - The final write strobe of a row precedes the first read strobe of any window using that row by at least one cycle.
- Output timing:
  - out_valid = en_rd delayed 2 cycles (BRAM latency + data_rd register).
  - out_last is aligned with the final column of window K-1.
  - There is no output backpressure. The consumer deasserts rd_ready at least 2 cycles ahead of need.
- Unused row: when H-5 is odd, the last row is written but never read.
- Simultaneous events: a window completion and a row completion in the same cycle both update. in_ready uses the pre-update counters.
- Reset mid-operation: immediate return to IDLE with all outputs 0. In-flight out_valid is discarded. BRAM contents are don't-care.

Test Plan:
- W=4, H=7, continuous input, rd_ready=1 -> en_wr cycles 0x01..0x20 then 0x01. Two windows with order 001 then 010. 8 out_valid beats; out_last on beat 8; done one pulse.
- W=4, H=11 -> 4 windows, order sequence 001, 010, 100, 001. Window 3 reads BRAMs 0..4 holding rows 6..10.
- W=8, H=9, rd_ready=0 -> in_ready drops after 48 accepted words (6 rows). Raising rd_ready releases row 6 only after window 0 col 7 is issued.
- W=512, H=5, random in_valid gaps -> addr_wr and addr_rd sweep 0..511 with no wrap error. Exactly 512 out_valid beats; en_rd never asserted before the row-4 final write plus 1 cycle.
- Assert rst during window 1 of W=4, H=9 -> all outputs 0 asynchronously, out_valid suppressed. A new start with W=2, H=5 completes normally with 2 beats.
- W=1, H=6 -> 1 window, 1 beat. Row 5 is written to BRAM 5 and is never read.

Source files
------------

// File: rtl/one_channel_bram_ctrl.sv
// Write/read sequencer for the six-line, single-channel input line buffer.
// Row r is written to BRAM (r mod 6); 5-row windows at stride 2 are read with a one-hot rotation code.
module one_channel_bram_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_W      = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [9:0]               cfg_width,
    input  logic [9:0]               cfg_height,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [5:0]               en_wr,
    output logic [$clog2(MAX_W)-1:0] addr_wr,
    output logic [DATA_WIDTH-1:0]    data_wr,
    input  logic                     rd_ready,
    output logic                     en_rd,
    output logic [2:0]               order,
    output logic [$clog2(MAX_W)-1:0] addr_rd_0,
    output logic [$clog2(MAX_W)-1:0] addr_rd_1,
    output logic [$clog2(MAX_W)-1:0] addr_rd_2,
    output logic [$clog2(MAX_W)-1:0] addr_rd_3,
    output logic [$clog2(MAX_W)-1:0] addr_rd_4,
    output logic [$clog2(MAX_W)-1:0] addr_rd_5,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t          state;
    logic [9:0]      width_r;
    logic [9:0]      height_r;
    logic [9:0]      k_total;
    logic [9:0]      rows_written;
    logic [9:0]      windows_done;
    logic [AW-1:0]   wr_col;
    logic [AW-1:0]   rd_col;
    logic [AW-1:0]   addr_rd_q;
    logic [2:0]      wr_bank;
    logic [1:0]      win_mod3;
    logic            flush_cnt;
    logic            valid_d1;
    logic            last_d0;
    logic            last_d1;

    logic [10:0]     rows_ext;
    logic [10:0]     win_limit;
    logic            wr_last;
    logic            rd_last;
    logic            rd_eligible;
    logic            accept;
    logic            issue;

    // Window k needs rows up to 2k+4 written; rows up to 2k+5 may be written while it is read.
    assign rows_ext    = {1'b0, rows_written};
    assign win_limit   = {windows_done, 1'b0} + 11'd5;
    assign in_ready    = (state == RUN) && (rows_written < height_r) && (rows_ext <= win_limit);
    assign rd_eligible = (rows_ext >= win_limit) && (windows_done < k_total);
    assign accept      = in_valid && in_ready;
    assign issue       = (state == RUN) && rd_eligible && rd_ready;
    assign wr_last     = (10'(wr_col) == width_r - 10'd1);
    assign rd_last     = (10'(rd_col) == width_r - 10'd1);

    assign addr_rd_0 = addr_rd_q;
    assign addr_rd_1 = addr_rd_q;
    assign addr_rd_2 = addr_rd_q;
    assign addr_rd_3 = addr_rd_q;
    assign addr_rd_4 = addr_rd_q;
    assign addr_rd_5 = addr_rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            width_r      <= '0;
            height_r     <= '0;
            k_total      <= '0;
            rows_written <= '0;
            windows_done <= '0;
            wr_col       <= '0;
            rd_col       <= '0;
            addr_rd_q    <= '0;
            wr_bank      <= '0;
            win_mod3     <= '0;
            flush_cnt    <= 1'b0;
            valid_d1     <= 1'b0;
            last_d0      <= 1'b0;
            last_d1      <= 1'b0;
            en_wr        <= '0;
            addr_wr      <= '0;
            data_wr      <= '0;
            en_rd        <= 1'b0;
            order        <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            en_wr     <= '0;
            en_rd     <= 1'b0;
            order     <= '0;
            last_d0   <= 1'b0;
            done      <= 1'b0;
            // Two-stage delay covers BRAM read latency plus the line buffer's data_rd register.
            valid_d1  <= en_rd;
            out_valid <= valid_d1;
            last_d1   <= last_d0;
            out_last  <= last_d1;

            case (state)
                IDLE: begin
                    if (start) begin
                        width_r      <= cfg_width;
                        height_r     <= cfg_height;
                        k_total      <= ((cfg_height - 10'd5) >> 1) + 10'd1;
                        rows_written <= '0;
                        windows_done <= '0;
                        wr_col       <= '0;
                        rd_col       <= '0;
                        wr_bank      <= '0;
                        win_mod3     <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end

                RUN: begin
                    if (accept) begin
                        en_wr   <= 6'd1 << wr_bank;
                        addr_wr <= wr_col;
                        data_wr <= in_data;
                        if (wr_last) begin
                            wr_col       <= '0;
                            rows_written <= rows_written + 10'd1;
                            wr_bank      <= (wr_bank == 3'd5) ? 3'd0 : wr_bank + 3'd1;
                        end else begin
                            wr_col <= wr_col + AW'(1);
                        end
                    end

                    if (issue) begin
                        en_rd     <= 1'b1;
                        addr_rd_q <= rd_col;
                        order     <= {win_mod3 == 2'd2, win_mod3 == 2'd1, win_mod3 == 2'd0};
                        if (rd_last) begin
                            rd_col       <= '0;
                            windows_done <= windows_done + 10'd1;
                            win_mod3     <= (win_mod3 == 2'd2) ? 2'd0 : win_mod3 + 2'd1;
                            last_d0      <= (windows_done == k_total - 10'd1);
                        end else begin
                            rd_col <= rd_col + AW'(1);
                        end
                    end

                    if ((rows_written == height_r) && (windows_done == k_total)) begin
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end
                end

                FLUSH: begin
                    if (flush_cnt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
